fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the fetch PC and drives the instruction-side SRAM-like bus (one outstanding transaction). It applies redirect requests (exception, eret, branch, jump) with fixed priority and discards responses that a redirect has made stale. It holds one fetched instruction until the decode stage accepts it. It sits between the redirect logic of ID/EX/CP0 and the instruction memory port.

---
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a one-outstanding SRAM-like bus, applies redirects.
// Optional FETCH_ADEL_EN: misaligned fetch PCs become an address-error entry instead of a bus request.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_adel,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        kill_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_adel_q;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

`ifdef FETCH_ADEL_EN
    assign misaligned = |fetch_pc_q[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        redirect = exc_req | eret_req | br_req | j_req;
        if (exc_req)       redirect_pc = EXC_VECTOR;
        else if (eret_req) redirect_pc = epc;
        else if (br_req)   redirect_pc = br_target;
        else               redirect_pc = j_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            kill_q      <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            inst_adel_q <= 1'b0;
        end else begin
            if (redirect)
                fetch_pc_q <= redirect_pc;
            unique case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (misaligned) begin
                        // A same-cycle redirect replaces the bad PC, so no error entry is produced.
                        if (!redirect) begin
                            state_q     <= S_HOLD;
                            inst_q      <= '0;
                            inst_pc_q   <= fetch_pc_q;
                            inst_adel_q <= 1'b1;
                        end
                    end else if (inst_addr_ok) begin
                        state_q <= S_WAIT;
                        kill_q  <= redirect;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        kill_q <= 1'b0;
                        if (kill_q || redirect) begin
                            state_q <= S_REQ;
                        end else begin
                            state_q     <= S_HOLD;
                            inst_q      <= inst_rdata;
                            inst_pc_q   <= fetch_pc_q;
                            inst_adel_q <= 1'b0;
                            fetch_pc_q  <= fetch_pc_q + 32'd4;
                        end
                    end else if (redirect) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect || id_ready)
                        state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign inst_req   = (state_q == S_REQ) && !misaligned;
    assign inst_addr  = fetch_pc_q;
    assign inst_valid = (state_q == S_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_adel  = inst_adel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; bus handshakes are driven by hand step by step.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req, eret_req, br_req, j_req, id_ready;
    logic [31:0] epc, br_target, j_target;
    logic        inst_valid, inst_adel, inst_req;
    logic [31:0] inst, inst_pc, inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;

    int unsigned total = 0;
    int unsigned fails = 0;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .br_req       (br_req),
        .br_target    (br_target),
        .j_req        (j_req),
        .j_target     (j_target),
        .id_ready     (id_ready),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_adel    (inst_adel),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_pc;
    logic [31:0] word;

    initial begin
        rst = 1'b1;
        {exc_req, eret_req, br_req, j_req} = '0;
        epc = '0; br_target = '0; j_target = '0;
        id_ready = 1'b1;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

        // reset: two cycles high
        tick;
        chk("rst_req0", {31'b0, inst_req}, 32'd0);
        tick;
        chk("rst_req1", {31'b0, inst_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_adel", {31'b0, inst_adel}, 32'd0);
        rst = 1'b0;
        chk("rel_c1_req", {31'b0, inst_req}, 32'd0);
        tick;
        chk("rel_c2_req", {31'b0, inst_req}, 32'd1);
        chk("rel_c2_addr", inst_addr, 32'hBFC0_0000);

        // three sequential zero-wait fetches, one per 3 cycles
        exp_pc = 32'hBFC0_0000;
        for (int i = 0; i < 3; i++) begin
            word = 32'h1000_0000 + 32'(i);
            chk("seq_req", {31'b0, inst_req}, 32'd1);
            chk("seq_addr", inst_addr, exp_pc);
            inst_addr_ok = 1'b1;
            tick;
            inst_addr_ok = 1'b0;
            chk("seq_wait_req", {31'b0, inst_req}, 32'd0);
            inst_data_ok = 1'b1; inst_rdata = word;
            tick;
            inst_data_ok = 1'b0;
            chk("seq_valid", {31'b0, inst_valid}, 32'd1);
            chk("seq_inst", inst, word);
            chk("seq_pc", inst_pc, exp_pc);
            tick;
            exp_pc = exp_pc + 32'd4;
        end

        // stall in HOLD for 5 cycles
        id_ready = 1'b0;
        chk("stall_addr0", inst_addr, 32'hBFC0_000C);
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hA5A5_0001;
        tick;
        inst_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_inst", inst, 32'hA5A5_0001);
            chk("stall_pc", inst_pc, 32'hBFC0_000C);
            chk("stall_req", {31'b0, inst_req}, 32'd0);
            tick;
        end
        id_ready = 1'b1;
        tick;
        chk("unstall_req", {31'b0, inst_req}, 32'd1);
        chk("unstall_addr", inst_addr, 32'hBFC0_0010);

        // kill: branch one cycle after addr_ok, data_ok three cycles later
        id_ready = 1'b0;
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0;
        br_req = 1'b1; br_target = 32'hBFC0_0100;
        tick;
        br_req = 1'b0;
        chk("kill_wait_req", {31'b0, inst_req}, 32'd0);
        tick;
        tick;
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick;
        inst_data_ok = 1'b0;
        chk("kill_valid", {31'b0, inst_valid}, 32'd0);
        chk("kill_inst", inst, 32'hA5A5_0001);
        chk("kill_req", {31'b0, inst_req}, 32'd1);
        chk("kill_addr", inst_addr, 32'hBFC0_0100);
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
        tick;
        inst_data_ok = 1'b0;
        chk("kill_next_valid", {31'b0, inst_valid}, 32'd1);
        chk("kill_next_inst", inst, 32'h1111_1111);
        chk("kill_next_pc", inst_pc, 32'hBFC0_0100);

        // priority in HOLD: exc beats eret and branch, id_ready ignored
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h8000_0000;
        br_req = 1'b1; br_target = 32'hBFC0_0200; id_ready = 1'b1;
        tick;
        {exc_req, eret_req, br_req} = '0;
        id_ready = 1'b0;
        chk("prio_valid", {31'b0, inst_valid}, 32'd0);
        chk("prio_req", {31'b0, inst_req}, 32'd1);
        chk("prio_addr", inst_addr, 32'hBFC0_0380);

        // eret beats branch while REQ is pending without addr_ok
        eret_req = 1'b1; br_req = 1'b1;
        tick;
        {eret_req, br_req} = '0;
        chk("eret_req", {31'b0, inst_req}, 32'd1);
        chk("eret_addr", inst_addr, 32'h8000_0000);

        // redirect coinciding with data_ok: data dropped, no kill left behind
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
        j_req = 1'b1; j_target = 32'hBFC0_0200;
        tick;
        inst_data_ok = 1'b0; j_req = 1'b0;
        chk("wdrop_valid", {31'b0, inst_valid}, 32'd0);
        chk("wdrop_addr", inst_addr, 32'hBFC0_0200);
        inst_addr_ok = 1'b1;
        tick;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h2222_2222;
        tick;
        inst_data_ok = 1'b0;
        chk("wdrop_next_inst", inst, 32'h2222_2222);
        chk("wdrop_next_pc", inst_pc, 32'hBFC0_0200);

        // misaligned jump target
        j_req = 1'b1; j_target = 32'hBFC0_0102;
        tick;
        j_req = 1'b0;
`ifdef FETCH_ADEL_EN
        chk("mis_req_off", {31'b0, inst_req}, 32'd0);
        tick;
        chk("mis_req_hold", {31'b0, inst_req}, 32'd0);
        chk("mis_valid", {31'b0, inst_valid}, 32'd1);
        chk("mis_adel", {31'b0, inst_adel}, 32'd1);
        chk("mis_pc", inst_pc, 32'hBFC0_0102);
        chk("mis_inst", inst, 32'd0);
`else
        chk("mis_req", {31'b0, inst_req}, 32'd1);
        chk("mis_addr", inst_addr, 32'hBFC0_0102);
        chk("mis_adel", {31'b0, inst_adel}, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
